elevator_controller: RTL and testbench

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/elevator_controller_call_register.sv | 53 +++++
 rtl/elevator_controller.sv | 152 +++++++++++++++
 tb/tb_elevator_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared state encoding, default dimensions and a small helper
//                for the elevator controller and its call register.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    localparam int c_DEF_NUM_FLOORS   = 4;
    localparam int c_DEF_DOOR_TICKS   = 3;
    localparam int c_DEF_TRAVEL_TICKS = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_controller_call_register.sv
`default_nettype none
// ============================================================================
//  Module      : call_register
//  Description : Latches floor calls until served and reports whether any
//                call (latched or arriving this cycle) lies above or below
//                the current floor.
//  Revision    : 1.0 - initial release
// ============================================================================
module call_register
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS = c_DEF_NUM_FLOORS,
    localparam int c_FLOOR_W  = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
)(
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [NUM_FLOORS-1:0] i_set,
    input  logic [NUM_FLOORS-1:0] i_clr,
    input  logic [c_FLOOR_W-1:0]  i_floor,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_ahead_above,
    output logic                  o_ahead_below
);

    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_calls;

    // Clear only ever names the served floor, so clearing after the set
    // lets new calls elsewhere survive while the served floor drops out.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | i_set) & ~i_clr;
        end
    end

    assign w_calls = r_pending | i_set;

    // Scan the combined call view for anything above or below the cabin.
    always_comb begin
        o_ahead_above = 1'b0;
        o_ahead_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_calls[i] && (i > int'(i_floor))) o_ahead_above = 1'b1;
            if (w_calls[i] && (i < int'(i_floor))) o_ahead_below = 1'b1;
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_controller
//  Description : SCAN-scheduled single-cabin elevator: FSM, travel/door timer
//                and floor counter; call latching lives in call_register.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int  NUM_FLOORS   = c_DEF_NUM_FLOORS,
    parameter int  DOOR_TICKS   = c_DEF_DOOR_TICKS,
    parameter int  TRAVEL_TICKS = c_DEF_TRAVEL_TICKS,
    localparam int c_FLOOR_W    = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
)(
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  full,
    input  logic                  obstruct,
    output logic                  door_open,
    output logic [c_FLOOR_W-1:0]  floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  overload
);

    localparam int                    c_TIMER_W     = $clog2(max_int(DOOR_TICKS, TRAVEL_TICKS) + 1);
    localparam logic [c_TIMER_W-1:0]  c_DOOR_LAST   = c_TIMER_W'(DOOR_TICKS - 1);
    localparam logic [c_TIMER_W-1:0]  c_TRAVEL_LAST = c_TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [c_FLOOR_W-1:0]  c_TOP         = c_FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [NUM_FLOORS-1:0] c_ONE_HOT     = NUM_FLOORS'(1);

    state_t                r_state,  w_state_nxt;
    logic [c_FLOOR_W-1:0]  r_floor,  w_floor_nxt;
    logic                  r_dir_up, w_dir_nxt;
    logic [c_TIMER_W-1:0]  r_timer,  w_timer_nxt;

    logic [NUM_FLOORS-1:0] w_set;
    logic [NUM_FLOORS-1:0] w_clr;
    logic [NUM_FLOORS-1:0] w_pending;
    logic [NUM_FLOORS-1:0] w_here;
    logic                  w_above;
    logic                  w_below;
    logic [c_FLOOR_W-1:0]  w_move_floor;
    logic                  w_eff_dir;

    call_register #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_call_register (
        .clk           (clk),
        .nreset        (nreset),
        .i_set         (w_set),
        .i_clr         (w_clr),
        .i_floor       (r_floor),
        .o_pending     (w_pending),
        .o_ahead_above (w_above),
        .o_ahead_below (w_below)
    );

    assign w_here = c_ONE_HOT << r_floor;

    // Departure direction is pinned at the end floors so the cabin can never
    // be aimed off the shaft.
    assign w_eff_dir = (r_floor == '0)   ? 1'b1 :
                       (r_floor == c_TOP) ? 1'b0 : r_dir_up;

    // Next floor one step along the travel direction, saturated at the ends.
    always_comb begin
        if (r_dir_up) begin
            w_move_floor = (r_floor == c_TOP) ? r_floor : r_floor + 1'b1;
        end else begin
            w_move_floor = (r_floor == '0) ? r_floor : r_floor - 1'b1;
        end
    end

    // State register with asynchronous reset; reset abandons any travel or door cycle.
    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state  <= IDLE;
            r_floor  <= '0;
            r_dir_up <= 1'b1;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_floor  <= w_floor_nxt;
            r_dir_up <= w_dir_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    // Next-state, timer and call set/clear decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = r_floor;
        w_dir_nxt   = r_dir_up;
        w_timer_nxt = r_timer + 1'b1;
        w_set       = call_req;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                if (|((w_pending | call_req) & w_here)) begin
                    w_state_nxt = DOOR_OPEN;
                    w_clr       = w_here;
                end else if (w_eff_dir ? w_above : w_below) begin
                    w_state_nxt = MOVING;
                    w_dir_nxt   = w_eff_dir;
                end else if (w_eff_dir ? w_below : w_above) begin
                    w_state_nxt = MOVING;
                    w_dir_nxt   = ~w_eff_dir;
                end
            end
            MOVING: begin
                if (r_timer == c_TRAVEL_LAST) begin
                    w_timer_nxt = '0;
                    w_floor_nxt = w_move_floor;
                    if (w_pending[w_move_floor]) begin
                        w_state_nxt = DOOR_OPEN;
                        w_clr       = c_ONE_HOT << w_move_floor;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for this floor just holds the door longer.
                w_set = call_req & ~w_here;
                if (call_req[r_floor]) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_DOOR_LAST) begin
                    w_timer_nxt = '0;
                    if (!full && !obstruct) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign door_open = (r_state == DOOR_OPEN);
    assign moving    = (r_state == MOVING);
    assign floor     = r_floor;
    assign dir_up    = r_dir_up;
    assign pending   = w_pending;
    assign overload  = full && door_open;

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_controller
//  Description : Self-checking bench: directed scenarios plus random calls,
//                load and obstruction against a behavioural cabin model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_controller;

    localparam int NF = 4;
    localparam int DT = 3;
    localparam int TT = 2;

    logic          clk      = 1'b0;
    logic          nreset   = 1'b1;
    logic [NF-1:0] call_req = '0;
    logic          full     = 1'b0;
    logic          obstruct = 1'b0;
    logic          door_open;
    logic [1:0]    floor;
    logic          moving;
    logic          dir_up;
    logic [NF-1:0] pending;
    logic          overload;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural cabin model
    int            m_floor;
    bit            m_up;
    bit            m_door;
    bit            m_travel;
    int            m_cnt;
    logic [NF-1:0] m_pend;

    bit prev_door;
    int stops[$];

    elevator_controller #(
        .NUM_FLOORS   (NF),
        .DOOR_TICKS   (DT),
        .TRAVEL_TICKS (TT)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .call_req  (call_req),
        .full      (full),
        .obstruct  (obstruct),
        .door_open (door_open),
        .floor     (floor),
        .moving    (moving),
        .dir_up    (dir_up),
        .pending   (pending),
        .overload  (overload)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        m_floor  = 0;
        m_up     = 1'b1;
        m_door   = 1'b0;
        m_travel = 1'b0;
        m_cnt    = 0;
        m_pend   = '0;
    endfunction

    function automatic bit calls_toward(input bit up);
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && (up ? (i > m_floor) : (i < m_floor))) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge of cabin behaviour for the given inputs.
    function automatic void model_step(input logic [NF-1:0] c, input logic f, input logic o);
        logic [NF-1:0] old;
        bit            eff;
        old = m_pend;
        if (m_door) begin
            for (int i = 0; i < NF; i++) if (c[i] && i != m_floor) m_pend[i] = 1'b1;
            if (c[m_floor]) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == DT) begin
                    m_cnt = 0;
                    if (!f && !o) m_door = 1'b0;
                end
            end
        end else if (m_travel) begin
            m_pend = old | c;
            m_cnt++;
            if (m_cnt == TT) begin
                m_cnt   = 0;
                m_floor = m_up ? m_floor + 1 : m_floor - 1;
                if (old[m_floor]) begin
                    m_travel        = 1'b0;
                    m_door          = 1'b1;
                    m_pend[m_floor] = 1'b0;
                end
            end
        end else begin
            m_pend = old | c;
            m_cnt  = 0;
            if (m_pend[m_floor]) begin
                m_door          = 1'b1;
                m_pend[m_floor] = 1'b0;
            end else begin
                eff = (m_floor == 0) ? 1'b1 : (m_floor == NF - 1) ? 1'b0 : m_up;
                if (calls_toward(eff)) begin
                    m_travel = 1'b1;
                    m_up     = eff;
                end else if (calls_toward(!eff)) begin
                    m_travel = 1'b1;
                    m_up     = !eff;
                end
            end
        end
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, "_floor"},    int'(floor),     m_floor);
        check_eq({tag, "_door"},     int'(door_open), int'(m_door));
        check_eq({tag, "_moving"},   int'(moving),    int'(m_travel));
        check_eq({tag, "_dir_up"},   int'(dir_up),    int'(m_up));
        check_eq({tag, "_pending"},  int'(pending),   int'(m_pend));
        check_eq({tag, "_overload"}, int'(overload),  int'(m_door && full));
    endtask

    // Drive inputs at a falling edge, let one rising edge pass, compare.
    task automatic tick(input logic [NF-1:0] c, input logic f, input logic o);
        call_req = c;
        full     = f;
        obstruct = o;
        model_step(c, f, o);
        @(negedge clk);
        compare_all("cyc");
        if (door_open && !prev_door) stops.push_back(int'(floor));
        prev_door = door_open;
    endtask

    // Mid-cycle asynchronous reset with the given calls held during it.
    task automatic apply_reset(input logic [NF-1:0] c_during);
        #2;
        nreset   = 1'b1;
        call_req = c_during;
        model_reset();
        #1;
        compare_all("rst");
        @(negedge clk);
        @(negedge clk);
        nreset    = 1'b0;
        call_req  = '0;
        full      = 1'b0;
        obstruct  = 1'b0;
        prev_door = 1'b0;
    endtask

    initial begin
        logic [NF-1:0] rc;
        model_reset();
        prev_door = 1'b0;

        // reset state
        @(negedge clk);
        check_eq("rst_floor",    int'(floor),     0);
        check_eq("rst_door",     int'(door_open), 0);
        check_eq("rst_moving",   int'(moving),    0);
        check_eq("rst_dir_up",   int'(dir_up),    1);
        check_eq("rst_pending",  int'(pending),   0);
        check_eq("rst_overload", int'(overload),  0);
        nreset = 1'b0;

        // single call to the top floor
        tick(4'b1000, 0, 0);
        check_eq("top_moving", int'(moving), 1);
        check_eq("top_dir",    int'(dir_up), 1);
        repeat (2) tick('0, 0, 0);
        check_eq("top_f1", int'(floor), 1);
        repeat (2) tick('0, 0, 0);
        check_eq("top_f2", int'(floor), 2);
        repeat (2) tick('0, 0, 0);
        check_eq("top_f3",      int'(floor),     3);
        check_eq("top_door",    int'(door_open), 1);
        check_eq("top_pending", int'(pending),   0);
        repeat (2) tick('0, 0, 0);
        check_eq("top_door_hold", int'(door_open), 1);
        tick('0, 0, 0);
        check_eq("top_door_close", int'(door_open), 0);

        // call at the current floor, then full at door expiry
        apply_reset('0);
        tick(4'b0001, 0, 0);
        check_eq("here_door",    int'(door_open), 1);
        check_eq("here_moving",  int'(moving),    0);
        check_eq("here_pending", int'(pending),   0);
        repeat (3) tick('0, 1, 0);
        check_eq("full_door",     int'(door_open), 1);
        check_eq("full_overload", int'(overload),  1);
        repeat (2) tick('0, 0, 0);
        check_eq("full_hold", int'(door_open), 1);
        tick('0, 0, 0);
        check_eq("full_close", int'(door_open), 0);

        // obstruction holds door; same-floor call restarts the timer
        apply_reset('0);
        tick(4'b0001, 0, 0);
        repeat (3) tick('0, 0, 1);
        check_eq("obs_door", int'(door_open), 1);
        tick('0, 0, 0);
        tick(4'b0001, 0, 0);
        check_eq("restart_pending", int'(pending), 0);
        repeat (2) tick('0, 0, 0);
        check_eq("restart_hold", int'(door_open), 1);
        tick('0, 0, 0);
        check_eq("restart_close", int'(door_open), 0);

        // SCAN ordering: up through 1 and 3, then back to 0
        apply_reset('0);
        stops.delete();
        tick(4'b1010, 0, 0);
        tick(4'b0001, 0, 0);
        repeat (40) tick('0, 0, 0);
        check_eq("scan_nstops", stops.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("scan_stop%0d", k), (stops.size() > k) ? stops[k] : -1, (k == 0) ? 1 : (k == 1) ? 3 : 0);
        end

        // reset while travelling between floors 1 and 2
        apply_reset('0);
        tick(4'b0100, 0, 0);
        repeat (2) tick('0, 0, 0);
        check_eq("mid_f1",     int'(floor),  1);
        check_eq("mid_moving", int'(moving), 1);
        tick('0, 0, 0);
        apply_reset(4'b0100);
        check_eq("mid_rst_floor",  int'(floor),   0);
        check_eq("mid_rst_moving", int'(moving),  0);
        tick('0, 0, 0);
        check_eq("mid_rst_nolatch", int'(pending), 0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 249) == 0) begin
                apply_reset(NF'($urandom));
            end else begin
                rc = ($urandom_range(0, 4) == 0) ? (NF'(1) << $urandom_range(0, NF - 1)) : '0;
                tick(rc, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
